// File: rtl/umem_pkg.sv
// Shared types and funct3 helpers for the unified-memory port arbiter.
// Size and legality decoding live here so the top stays focused on sequencing.
package umem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, XFER, RDWAIT, DONE} umem_arb_state_t;
  typedef enum logic {SRC_CORE, SRC_AXI} umem_src_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic w_ok;
    w_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) w_ok = w_ok || (f3 == F3_BU) || (f3 == F3_HU);
    return w_ok;
  endfunction

  // Index of the final byte of the access, i.e. size minus one.
  function automatic logic [1:0] f3_last_idx(input logic [2:0] f3);
    logic [1:0] w_idx;
    case (f3)
      F3_H, F3_HU: w_idx = 2'd1;
      F3_W:        w_idx = 2'd3;
      default:     w_idx = 2'd0;
    endcase
    return w_idx;
  endfunction

endpackage

// File: rtl/umem_addr_step.sv
// Next byte address of a serialised access. Core addresses wrap modulo the
// memory depth; AXI addresses fold the top byte back onto WRAP_BASE.
module umem_addr_step
  import umem_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int WRAP_BASE = 256
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  umem_src_t         i_src,
  output logic [ADDR_W-1:0] o_next
);

  localparam logic [ADDR_W-1:0] LP_TOP  = '1;
  localparam logic [ADDR_W-1:0] LP_WRAP = ADDR_W'(WRAP_BASE);

  always_comb begin
    o_next = i_addr + ADDR_W'(1);
    if ((i_src == SRC_AXI) && (i_addr == LP_TOP)) o_next = LP_WRAP;
  end

endmodule

// File: rtl/umem_port_arbiter.sv
// Round-robin sharing of the byte-wide unified memory port between the core
// load/store port and the AXI word port, one memory byte per cycle.
module umem_port_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int WRAP_BASE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_ack,
  output logic              core_err,
  output logic [31:0]       core_rdata,
  input  logic              axi_req,
  input  logic              axi_we,
  input  logic [ADDR_W-1:0] axi_addr,
  input  logic [31:0]       axi_wdata,
  output logic              axi_ack,
  output logic [31:0]       axi_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wbyte,
  input  logic [7:0]        mem_rbyte
);

  umem_arb_state_t   r_state, w_nextState;
  umem_src_t         r_src, r_lastGrant, w_grantSrc;
  logic              r_we, r_err, r_rdPend;
  logic [2:0]        r_funct3;
  logic [1:0]        r_cnt, r_lastIdx, r_rdIdx;
  logic [ADDR_W-1:0] r_addr, w_nextAddr, w_selAddr;
  logic [31:0]       r_wdata, r_rdata, w_selWdata, w_ext;
  logic              w_anyReq, w_selWe, w_grantLegal;
  logic [2:0]        w_selF3;

  umem_addr_step #(.ADDR_W(ADDR_W), .WRAP_BASE(WRAP_BASE)) u_addr_step (
    .i_addr (r_addr),
    .i_src  (r_src),
    .o_next (w_nextAddr)
  );

  // On a tie the side that did not win last time is granted.
  always_comb begin
    w_anyReq   = core_req | axi_req;
    w_grantSrc = SRC_AXI;
    if (core_req && (!axi_req || (r_lastGrant == SRC_AXI))) w_grantSrc = SRC_CORE;
    w_selWe    = (w_grantSrc == SRC_CORE) ? core_we     : axi_we;
    w_selF3    = (w_grantSrc == SRC_CORE) ? core_funct3 : F3_W;
    w_selAddr  = (w_grantSrc == SRC_CORE) ? core_addr   : axi_addr;
    w_selWdata = (w_grantSrc == SRC_CORE) ? core_wdata  : axi_wdata;
    w_grantLegal = f3_legal(w_selWe, w_selF3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = w_grantLegal ? XFER : DONE;
      XFER:    if (r_cnt == r_lastIdx) w_nextState = r_we ? DONE : RDWAIT;
      RDWAIT:  w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Read bytes return one cycle after issue, so capture trails issue by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src       <= SRC_CORE;
      r_lastGrant <= SRC_AXI;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= 3'b000;
      r_cnt       <= 2'd0;
      r_lastIdx   <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rdPend    <= 1'b0;
      r_rdIdx     <= 2'd0;
    end else begin
      r_rdPend <= (r_state == XFER) && !r_we;
      r_rdIdx  <= r_cnt;
      if (r_rdPend) r_rdata[{r_rdIdx, 3'b000} +: 8] <= mem_rbyte;
      case (r_state)
        IDLE: if (w_anyReq) begin
          r_src     <= w_grantSrc;
          r_we      <= w_selWe;
          r_funct3  <= w_selF3;
          r_addr    <= w_selAddr;
          r_wdata   <= w_selWdata;
          r_cnt     <= 2'd0;
          r_lastIdx <= f3_last_idx(w_selF3);
          r_err     <= !w_grantLegal;
          r_rdata   <= '0;
        end
        XFER: begin
          r_addr  <= w_nextAddr;
          r_wdata <= {8'h00, r_wdata[31:8]};
          r_cnt   <= r_cnt + 2'd1;
        end
        DONE:    r_lastGrant <= r_src;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_funct3)
      F3_B:    w_ext = {{24{r_rdata[7]}}, r_rdata[7:0]};
      F3_H:    w_ext = {{16{r_rdata[15]}}, r_rdata[15:0]};
      F3_BU:   w_ext = {24'h000000, r_rdata[7:0]};
      F3_HU:   w_ext = {16'h0000, r_rdata[15:0]};
      default: w_ext = r_rdata;
    endcase
    core_ack   = (r_state == DONE) && (r_src == SRC_CORE);
    axi_ack    = (r_state == DONE) && (r_src == SRC_AXI);
    core_err   = core_ack && r_err;
    core_rdata = (core_ack && !r_err && !r_we) ? w_ext : 32'h0;
    axi_rdata  = (axi_ack && !r_we) ? r_rdata : 32'h0;
    mem_en     = (r_state == XFER);
    mem_we     = mem_en && r_we;
    mem_addr   = mem_en ? r_addr : '0;
    mem_wbyte  = mem_we ? r_wdata[7:0] : 8'h00;
  end

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Bench for umem_port_arbiter: a byte memory model plus a reference model of
// the access rules (sizes, wrap, extension, latency, arbitration order).
module tb_umem_port_arbiter;

  localparam int ADDR_W    = 9;
  localparam int DEPTH     = 512;
  localparam int WRAP_BASE = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              core_req = 1'b0, core_we = 1'b0;
  logic [2:0]        core_funct3 = 3'b000;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [31:0]       core_wdata = '0;
  logic              core_ack, core_err;
  logic [31:0]       core_rdata;
  logic              axi_req = 1'b0, axi_we = 1'b0;
  logic [ADDR_W-1:0] axi_addr = '0;
  logic [31:0]       axi_wdata = '0;
  logic              axi_ack;
  logic [31:0]       axi_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wbyte;
  logic [7:0]        mem_rbyte;

  int errors = 0;
  int checks = 0;

  umem_port_arbiter #(.ADDR_W(ADDR_W), .WRAP_BASE(WRAP_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_ack(axi_ack), .axi_rdata(axi_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wbyte(mem_wbyte), .mem_rbyte(mem_rbyte)
  );

  always #5 clk = ~clk;

  logic [7:0] mem      [DEPTH];
  logic [7:0] fillData [DEPTH];
  logic [7:0] refMem   [DEPTH];
  logic       fillNow = 1'b0;
  int         seenAddr [$];

  // Byte memory with registered read data, preloadable while fillNow is high.
  always @(posedge clk) begin
    if (fillNow) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fillData[i];
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wbyte;
      else        mem_rbyte <= mem[mem_addr];
    end
    if (mem_en) seenAddr.push_back(int'(mem_addr));
  end

  function automatic int refSize(input bit isAxi, input logic [2:0] f3);
    if (isAxi) return 4;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit refLegal(input bit isAxi, input bit we, input logic [2:0] f3);
    if (isAxi) return 1'b1;
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int refAddr(input bit isAxi, input int start, input int k);
    int a;
    if (!isAxi) return (start + k) % DEPTH;
    a = start;
    for (int j = 0; j < k; j++) a = (a == DEPTH - 1) ? WRAP_BASE : a + 1;
    return a;
  endfunction

  function automatic logic [31:0] refLoad(input bit isAxi, input logic [2:0] f3, input int start);
    longint v = 0;
    longint scale = 1;
    for (int k = 0; k < refSize(isAxi, f3); k++) begin
      v += longint'(refMem[refAddr(isAxi, start, k)]) * scale;
      scale *= 256;
    end
    if (!isAxi && f3 == 3'd0 && v >= 128)   v -= 256;
    if (!isAxi && f3 == 3'd1 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  function automatic int refLatency(input bit isAxi, input bit we, input logic [2:0] f3);
    if (!refLegal(isAxi, we, f3)) return 1;
    return we ? refSize(isAxi, f3) + 1 : refSize(isAxi, f3) + 2;
  endfunction

  task automatic applyReset();
    rst_n = 1'b0;
    core_req = 1'b0;
    axi_req = 1'b0;
    fillNow = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fillNow = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = fillData[i];
    rst_n = 1'b1;
  endtask

  // Issues one access from an IDLE cycle and counts edges until its ack.
  task automatic runAccess(input bit isAxi, input bit we, input logic [2:0] f3,
                           input int addr, input logic [31:0] wdata,
                           output int latency, output logic [31:0] rdata,
                           output logic err, output int firstIdx);
    @(posedge clk);
    #1;
    firstIdx = seenAddr.size();
    if (isAxi) begin
      axi_req = 1'b1; axi_we = we; axi_addr = ADDR_W'(addr); axi_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_funct3 = f3;
      core_addr = ADDR_W'(addr); core_wdata = wdata;
    end
    latency = -1;
    rdata = 32'hxxxxxxxx;
    err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (isAxi ? axi_ack : core_ack) begin
        latency = c;
        rdata = isAxi ? axi_rdata : core_rdata;
        err = isAxi ? 1'b0 : core_err;
        break;
      end
    end
    core_req = 1'b0;
    axi_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [85:0] outs;
    applyReset();
    rst_n = 1'b0;
    #1;
    outs = {core_ack, core_err, core_rdata, axi_ack, axi_rdata, mem_en, mem_we, mem_addr, mem_wbyte};
    checks++;
    if (outs !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {core_ack, core_err, core_rdata, axi_ack, axi_rdata, mem_en, mem_we, mem_addr, mem_wbyte};
    checks++;
    if (outs !== '0) begin
      errors++; $display("[TB] FAIL idle_outputs: got %h expected 0", outs);
    end
  endtask

  typedef struct packed {
    logic        isAxi;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  lat;
    logic [31:0] expData;
    logic        useModel;
  } dirT;

  task automatic test_directed();
    dirT dir[9];
    int lat, first, n;
    logic [31:0] rd, expRd;
    logic er;
    bit ok;
    dir[0] = '{1'b0, 1'b1, 3'd2, 9'd8,   32'hCCBBAA99, 4'd5, 32'h0,        1'b0};
    dir[1] = '{1'b0, 1'b0, 3'd0, 9'd10,  32'h0,        4'd3, 32'hFFFFFFBB, 1'b0};
    dir[2] = '{1'b0, 1'b0, 3'd4, 9'd10,  32'h0,        4'd3, 32'h000000BB, 1'b0};
    dir[3] = '{1'b0, 1'b0, 3'd1, 9'd10,  32'h0,        4'd4, 32'hFFFFCCBB, 1'b0};
    dir[4] = '{1'b0, 1'b0, 3'd5, 9'd10,  32'h0,        4'd4, 32'h0000CCBB, 1'b0};
    dir[5] = '{1'b1, 1'b1, 3'd2, 9'd510, 32'h44332211, 4'd5, 32'h0,        1'b0};
    dir[6] = '{1'b0, 1'b0, 3'd2, 9'd511, 32'h0,        4'd6, 32'h0,        1'b1};
    dir[7] = '{1'b1, 1'b0, 3'd2, 9'd510, 32'h0,        4'd6, 32'h44332211, 1'b0};
    dir[8] = '{1'b0, 1'b1, 3'd1, 9'd511, 32'h0000A55A, 4'd3, 32'h0,        1'b0};
    for (int i = 0; i < 9; i++) begin
      n = refSize(dir[i].isAxi, dir[i].f3);
      expRd = dir[i].useModel ? refLoad(dir[i].isAxi, dir[i].f3, int'(dir[i].addr)) : dir[i].expData;
      runAccess(dir[i].isAxi, dir[i].we, dir[i].f3, int'(dir[i].addr), dir[i].wdata, lat, rd, er, first);
      checks++;
      if (lat !== int'(dir[i].lat) || er !== 1'b0) begin
        errors++; $display("[TB] FAIL dir%0d_latency: got %0d err %b expected %0d err 0", i, lat, er, dir[i].lat);
      end
      ok = (seenAddr.size() - first) == n;
      for (int k = 0; ok && k < n; k++)
        if (seenAddr[first + k] != refAddr(dir[i].isAxi, int'(dir[i].addr), k)) ok = 0;
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL dir%0d_addr_seq: got %0d bytes expected %0d from %0d", i, seenAddr.size() - first, n, dir[i].addr);
      end
      if (dir[i].we) begin
        for (int k = 0; k < n; k++) refMem[refAddr(dir[i].isAxi, int'(dir[i].addr), k)] = dir[i].wdata[8*k +: 8];
        ok = 1;
        for (int k = 0; k < n; k++)
          if (mem[refAddr(dir[i].isAxi, int'(dir[i].addr), k)] !== dir[i].wdata[8*k +: 8]) ok = 0;
        checks++;
        if (!ok) begin
          errors++; $display("[TB] FAIL dir%0d_mem_write: got bytes differing from %h expected %h", i, dir[i].wdata, dir[i].wdata);
        end
      end else begin
        checks++;
        if (rd !== expRd) begin
          errors++; $display("[TB] FAIL dir%0d_rdata: got %h expected %h", i, rd, expRd);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int lat, first, a;
    logic [31:0] rd;
    logic er;
    logic [2:0] badF3 [4];
    logic       badWe [4];
    badF3[0] = 3'd3; badWe[0] = 1'b0;
    badF3[1] = 3'd6; badWe[1] = 1'b0;
    badF3[2] = 3'd4; badWe[2] = 1'b1;
    badF3[3] = 3'd7; badWe[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      runAccess(1'b0, badWe[i], badF3[i], a, $urandom, lat, rd, er, first);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || seenAddr.size() != first) begin
        errors++;
        $display("[TB] FAIL illegal_f3_%0d: got lat %0d err %b rdata %h bytes %0d expected lat 1 err 1 rdata 0 bytes 0",
                 badF3[i], lat, er, rd, seenAddr.size() - first);
      end
    end
  endtask

  task automatic test_arbitration();
    int order [$];
    int expOrder [3];
    int both;
    logic [31:0] expAxi;
    expOrder[0] = 0; expOrder[1] = 1; expOrder[2] = 0;
    applyReset();
    @(posedge clk);
    #1;
    core_we = 1'b0; core_funct3 = 3'd2; core_addr = 9'd100;
    axi_we = 1'b0;  axi_addr = 9'd200;
    core_req = 1'b1; axi_req = 1'b1;
    both = 0;
    for (int c = 0; c < 60 && order.size() < 2; c++) begin
      @(posedge clk);
      #1;
      if (core_ack && axi_ack) both++;
      if (core_ack) begin order.push_back(0); core_req = 1'b0; end
      if (axi_ack)  begin order.push_back(1); axi_req = 1'b0; end
    end
    checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1 || both != 0) begin
      errors++; $display("[TB] FAIL tie_first_grant: got %0d acks first %0d expected core then axi", order.size(), order.size() > 0 ? order[0] : -1);
    end
    order.delete();
    expAxi = refLoad(1'b1, 3'd2, 200);
    @(posedge clk);
    #1;
    core_req = 1'b1; axi_req = 1'b1;
    for (int c = 0; c < 60 && order.size() < 3; c++) begin
      @(posedge clk);
      #1;
      if (core_ack && axi_ack) both++;
      if (core_ack) order.push_back(0);
      if (axi_ack) begin
        order.push_back(1);
        checks++;
        if (axi_rdata !== expAxi) begin
          errors++; $display("[TB] FAIL held_axi_rdata: got %h expected %h", axi_rdata, expAxi);
        end
      end
    end
    core_req = 1'b0; axi_req = 1'b0;
    checks++;
    if (order.size() != 3 || both != 0) begin
      errors++; $display("[TB] FAIL held_ack_count: got %0d acks expected 3", order.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (order[i] != expOrder[i]) begin
          errors++; $display("[TB] FAIL held_grant%0d: got %0d expected %0d", i, order[i], expOrder[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int a, lat, first;
    logic [31:0] wd, rd, expRd;
    logic [85:0] outs;
    logic er;
    bit sawAck;
    a = 510;
    wd = $urandom;
    @(posedge clk);
    #1;
    axi_we = 1'b1; axi_addr = ADDR_W'(a); axi_wdata = wd; axi_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== ADDR_W'(refAddr(1'b1, a, 2))) begin
      errors++; $display("[TB] FAIL third_byte_issue: got en %b addr %0d expected en 1 addr %0d", mem_en, mem_addr, refAddr(1'b1, a, 2));
    end
    rst_n = 1'b0;
    axi_req = 1'b0;
    #1;
    outs = {core_ack, core_err, core_rdata, axi_ack, axi_rdata, mem_en, mem_we, mem_addr, mem_wbyte};
    checks++;
    if (outs !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %h expected 0", outs);
    end
    sawAck = 0;
    repeat (2) begin @(posedge clk); #1; if (axi_ack) sawAck = 1; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (axi_ack || mem_en) sawAck = 1; end
    checks++;
    if (sawAck) begin
      errors++; $display("[TB] FAIL midreset_no_ack: got activity 1 expected 0");
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < 2) refMem[refAddr(1'b1, a, k)] = wd[8*k +: 8];
      if (mem[refAddr(1'b1, a, k)] !== refMem[refAddr(1'b1, a, k)]) begin
        errors++; $display("[TB] FAIL midreset_byte%0d: got %h expected %h", k, mem[refAddr(1'b1, a, k)], refMem[refAddr(1'b1, a, k)]);
      end
    end
    expRd = refLoad(1'b0, 3'd0, 511);
    runAccess(1'b0, 1'b0, 3'd0, 511, 32'h0, lat, rd, er, first);
    checks++;
    if (lat !== 3 || rd !== expRd) begin
      errors++; $display("[TB] FAIL post_reset_load: got lat %0d rdata %h expected lat 3 rdata %h", lat, rd, expRd);
    end
  endtask

  task automatic test_random();
    bit isAxi, we, legal, ok;
    logic [2:0] f3;
    logic [31:0] wd, rd, expRd;
    logic er;
    int a, n, lat, first, expLat;
    for (int it = 0; it < 40; it++) begin
      isAxi = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      f3    = isAxi ? 3'd2 : 3'($urandom_range(0, 7));
      a     = int'($urandom_range(0, DEPTH - 1));
      wd    = $urandom;
      legal = refLegal(isAxi, we, f3);
      n     = legal ? refSize(isAxi, f3) : 0;
      expLat = refLatency(isAxi, we, f3);
      expRd  = (legal && !we) ? refLoad(isAxi, f3, a) : 32'h0;
      runAccess(isAxi, we, f3, a, wd, lat, rd, er, first);
      checks++;
      if (lat !== expLat || er !== 1'(!legal)) begin
        errors++; $display("[TB] FAIL rnd%0d_latency: got %0d err %b expected %0d err %b", it, lat, er, expLat, !legal);
      end
      checks++;
      if (rd !== expRd) begin
        errors++; $display("[TB] FAIL rnd%0d_rdata: got %h expected %h", it, rd, expRd);
      end
      ok = (seenAddr.size() - first) == n;
      for (int k = 0; ok && k < n; k++)
        if (seenAddr[first + k] != refAddr(isAxi, a, k)) ok = 0;
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL rnd%0d_addr_seq: got %0d bytes expected %0d from %0d", it, seenAddr.size() - first, n, a);
      end
      if (legal && we) begin
        for (int k = 0; k < n; k++) refMem[refAddr(isAxi, a, k)] = wd[8*k +: 8];
        ok = 1;
        for (int k = 0; k < n; k++)
          if (mem[refAddr(isAxi, a, k)] !== refMem[refAddr(isAxi, a, k)]) ok = 0;
        checks++;
        if (!ok) begin
          errors++; $display("[TB] FAIL rnd%0d_mem_write: got mismatching bytes for %h expected %h", it, wd, wd);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) fillData[i] = 8'($urandom);
    test_reset();
    test_directed();
    test_illegal();
    test_arbitration();
    test_reset_midwrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
